dcache: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache: the responder to the pipeline's

---
 rtl/dcache_pkg.sv | 25 ++
 rtl/dcache_store_merge.sv | 37 +++
 rtl/dcache.sv | 156 +++++++++++++++
 tb/tb_dcache.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
//   Shared types for the L1 data cache: access-size encoding used on the
//   pipeline handshake, the cache controller state, and the line layout for
//   the default geometry (4 x 32-bit words, word 0 in the low bits).
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int unsigned DC_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } dcache_state_t;

  typedef logic [DC_LINE_WORDS-1:0][31:0] dcache_line_t;

endpackage

// File: rtl/dcache_store_merge.sv
// -----------------------------------------------------------------------------
// dcache_store_merge
//   Combinational byte-lane merge of a right-aligned store into one cache line.
//   Low address bits that do not fit the access size are ignored, so a
//   misaligned HALF/WORD store lands on its naturally aligned lanes.
// Ports
//   line_i      line before the store
//   word_idx_i  word within the line
//   byte_off_i  byte within the word (addr[1:0])
//   size_i      BYTE / HALF / WORD
//   data_i      store data, right-aligned
//   line_o      line after the store
// -----------------------------------------------------------------------------
module dcache_store_merge
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DC_LINE_WORDS
) (
  input  logic [LINE_WORDS-1:0][31:0]    line_i,
  input  logic [$clog2(LINE_WORDS)-1:0]  word_idx_i,
  input  logic [1:0]                     byte_off_i,
  input  mem_access_size_t               size_i,
  input  logic [31:0]                    data_i,
  output logic [LINE_WORDS-1:0][31:0]    line_o
);

  // NOTE: the default copy before the case keeps every path assigned, so no latch is inferred.
  always_comb begin
    line_o = line_i;
    case (size_i)
      SIZE_BYTE: line_o[word_idx_i][{byte_off_i, 3'b000} +: 8]     = data_i[7:0];
      SIZE_HALF: line_o[word_idx_i][{byte_off_i[1], 4'b0000} +: 16] = data_i[15:0];
      default:   line_o[word_idx_i]                                 = data_i;
    endcase
  end

endmodule

// File: rtl/dcache.sv
// -----------------------------------------------------------------------------
// dcache
//   Direct-mapped, write-back, write-allocate L1 data cache. Hits are answered
//   combinationally in the request cycle; a miss blocks while the controller
//   writes back a dirty victim and refills the line over a line-wide port.
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   access_i, addr_i        request valid and byte address
//   wr_en_i, size_i         store enable and access size
//   wr_data_i               right-aligned store data
//   rd_data_o, hit_o        word containing addr_i; request serviced this cycle
//   mem_rd_o, mem_wr_o      refill / writeback request, held until mem_ready_i
//   mem_addr_o              line-aligned memory address
//   mem_wr_data_o           victim line
//   mem_rd_data_i           refill line, sampled with mem_ready_i
//   mem_ready_i             completes the current memory request
// -----------------------------------------------------------------------------
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_WORDS = DC_LINE_WORDS,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     access_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic                     wr_en_i,
  input  mem_access_size_t         size_i,
  input  logic [31:0]              wr_data_i,
  output logic [31:0]              rd_data_o,
  output logic                     hit_o,
  output logic                     mem_rd_o,
  output logic                     mem_wr_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [32*LINE_WORDS-1:0] mem_wr_data_o,
  input  logic [32*LINE_WORDS-1:0] mem_rd_data_i,
  input  logic                     mem_ready_i
);

  localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
  localparam int unsigned OFFSET_W = $clog2(LINE_WORDS * 4);
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned WORD_W   = OFFSET_W - 2;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  // Storage
  line_t              data_q [NUM_LINES];
  logic [TAG_W-1:0]   tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  // Controller state and the request latched when the miss was taken
  dcache_state_t      state_q;
  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] req_index_q;

  // Address split of the live request
  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] addr_index;
  logic [WORD_W-1:0]  addr_word;
  logic               line_hit;
  logic               miss;
  logic               store_hit;
  logic               refill_done;
  line_t              merged_line;

  assign addr_tag   = addr_i[ADDR_W-1 -: TAG_W];
  assign addr_index = addr_i[OFFSET_W +: INDEX_W];
  assign addr_word  = addr_i[OFFSET_W-1:2];

  assign line_hit    = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  assign hit_o       = access_i && (state_q == ST_IDLE) && line_hit;
  assign miss        = access_i && (state_q == ST_IDLE) && !line_hit;
  assign store_hit   = hit_o && wr_en_i;
  assign refill_done = (state_q == ST_REFILL) && mem_ready_i;

  // Gated so the output is a clean zero whenever nothing is being serviced.
  assign rd_data_o = hit_o ? data_q[addr_index][addr_word] : '0;

  // Memory requests decode straight from the state register; they drop the
  // instant reset_i rises because the state flop resets asynchronously.
  assign mem_wr_o      = (state_q == ST_WRITEBACK);
  assign mem_rd_o      = (state_q == ST_REFILL);
  assign mem_wr_data_o = data_q[req_index_q];

  always_comb begin
    mem_addr_o = '0;
    case (state_q)
      ST_WRITEBACK: mem_addr_o = {tag_q[req_index_q], req_index_q, {OFFSET_W{1'b0}}};
      ST_REFILL:    mem_addr_o = {req_tag_q, req_index_q, {OFFSET_W{1'b0}}};
      default:      mem_addr_o = '0;
    endcase
  end

  dcache_store_merge #(
    .LINE_WORDS (LINE_WORDS)
  ) u_store_merge (
    .line_i     (data_q[addr_index]),
    .word_idx_i (addr_word),
    .byte_off_i (addr_i[1:0]),
    .size_i     (size_i),
    .data_i     (wr_data_i),
    .line_o     (merged_line)
  );

  // Controller FSM plus the valid/dirty bits it owns.
  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      req_tag_q   <= '0;
      req_index_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (miss) begin
            req_tag_q   <= addr_tag;
            req_index_q <= addr_index;
            state_q     <= (valid_q[addr_index] && dirty_q[addr_index]) ? ST_WRITEBACK
                                                                         : ST_REFILL;
          end else if (store_hit) begin
            dirty_q[addr_index] <= 1'b1;
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready_i) state_q <= ST_REFILL;
        end
        ST_REFILL: begin
          if (mem_ready_i) begin
            valid_q[req_index_q] <= 1'b1;
            dirty_q[req_index_q] <= 1'b0;
            state_q              <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: data and tag arrays carry no reset; valid_q alone decides whether their contents mean anything.
  always_ff @(posedge clk_i) begin
    if (store_hit) begin
      data_q[addr_index] <= merged_line;
    end
    if (refill_done) begin
      data_q[req_index_q] <= mem_rd_data_i;
      tag_q[req_index_q]  <= req_tag_q;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// -----------------------------------------------------------------------------
// tb_dcache
//   Self-checking bench for dcache. The reference is an architectural view of
//   memory (the value every word should read back as) plus a per-index record
//   of which line is resident and whether it has been stored to. Miss latency,
//   victim address/data, refill address and load data are all predicted from
//   that view. A simple memory responder answers refills from a backing store.
// -----------------------------------------------------------------------------
module tb_dcache;
  import dcache_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic                 access_i;
  logic [31:0]          addr_i;
  logic                 wr_en_i;
  mem_access_size_t     size_i;
  logic [31:0]          wr_data_i;
  logic [31:0]          rd_data_o;
  logic                 hit_o;
  logic                 mem_rd_o;
  logic                 mem_wr_o;
  logic [31:0]          mem_addr_o;
  logic [127:0]         mem_wr_data_o;
  logic [127:0]         mem_rd_data_i;
  logic                 mem_ready_i;

  dcache dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .access_i      (access_i),
    .addr_i        (addr_i),
    .wr_en_i       (wr_en_i),
    .size_i        (size_i),
    .wr_data_i     (wr_data_i),
    .rd_data_o     (rd_data_o),
    .hit_o         (hit_o),
    .mem_rd_o      (mem_rd_o),
    .mem_wr_o      (mem_wr_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_rd_data_i (mem_rd_data_i),
    .mem_ready_i   (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [31:0] arch_mem [int unsigned];  // architectural value per word address
  logic [31:0] back_mem [int unsigned];  // what the memory model actually holds
  bit          res_valid [64];
  logic [31:0] res_line  [64];
  bit          res_dirty [64];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] arch_word(input int unsigned w);
    return arch_mem.exists(w) ? arch_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] mem_word(input int unsigned w);
    return back_mem.exists(w) ? back_mem[w] : init_word(w);
  endfunction

  // What a word looks like after a store of the given size at byte offset b.
  function automatic logic [31:0] store_word(input logic [31:0] old, input logic [31:0] d,
                                             input mem_access_size_t sz, input logic [1:0] b);
    logic [31:0] mask;
    int          sh;
    case (sz)
      SIZE_BYTE: begin sh = 8 * int'(b);     mask = 32'h0000_00FF << sh; end
      SIZE_HALF: begin sh = 16 * int'(b[1]); mask = 32'h0000_FFFF << sh; end
      default:   begin sh = 0;               mask = 32'hFFFF_FFFF;       end
    endcase
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  // One pipeline request held until serviced, with the memory side answered
  // after wb_dly / rd_dly extra cycles. With drop_in_wb the request is
  // withdrawn (and addr_i scrambled) as soon as the writeback appears.
  task automatic do_access(input logic [31:0] a, input bit we, input mem_access_size_t sz,
                           input logic [31:0] d, input int wb_dly, input int rd_dly,
                           input bit drop_in_wb);
    logic [31:0] line_a   = a & 32'hFFFF_FFF0;
    int          idx      = int'(a[9:4]);
    bit          exp_miss = !(res_valid[idx] && res_line[idx] == line_a);
    bit          exp_wb   = exp_miss && res_valid[idx] && res_dirty[idx];
    int          exp_lat  = exp_miss ? (1 + (exp_wb ? wb_dly + 1 : 0) + rd_dly + 1) : 0;
    int          cyc      = 0;
    int          wait_cnt = 0;
    bit          wb_seen  = 0;
    bit          rd_seen  = 0;
    bit          refilled = 0;
    bit          done     = 0;
    logic [127:0] exp_line;

    access_i  = 1'b1;
    addr_i    = a;
    wr_en_i   = we;
    size_i    = sz;
    wr_data_i = d;
    while (!done && cyc < 200) begin
      #1;
      if (refilled && drop_in_wb) begin
        check("drop_idle_hit", hit_o, 1'b0);
        check("drop_idle_mem", {mem_rd_o, mem_wr_o}, 2'b00);
        done = 1;
      end else if (hit_o) begin
        check($sformatf("latency@%h", a), cyc, exp_lat);
        if (!we) check($sformatf("load@%h", a), rd_data_o, arch_word(a >> 2));
        done = 1;
      end else if (mem_wr_o) begin
        if (!wb_seen) begin
          wb_seen = 1;
          wait_cnt = 0;
          for (int w = 0; w < 4; w++) exp_line[32*w +: 32] = arch_word((res_line[idx] >> 2) + w);
          check("wb_addr", mem_addr_o, res_line[idx]);
          check("wb_data", mem_wr_data_o, exp_line);
          check("wb_no_rd", mem_rd_o, 1'b0);
          if (drop_in_wb) begin
            access_i = 1'b0;
            addr_i   = $urandom;
          end
        end
        if (wait_cnt == wb_dly) begin
          mem_ready_i = 1'b1;
          for (int w = 0; w < 4; w++) back_mem[(mem_addr_o >> 2) + w] = mem_wr_data_o[32*w +: 32];
        end
        wait_cnt++;
      end else if (mem_rd_o) begin
        if (!rd_seen) begin
          rd_seen = 1;
          wait_cnt = 0;
          check("rd_addr", mem_addr_o, line_a);
          check("wb_before_rd", wb_seen, exp_wb);
        end
        if (wait_cnt == rd_dly) begin
          mem_ready_i = 1'b1;
          for (int w = 0; w < 4; w++) mem_rd_data_i[32*w +: 32] = mem_word((line_a >> 2) + w);
          refilled = 1;
        end
        wait_cnt++;
      end
      if (!done) begin
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        cyc++;
      end
    end
    check($sformatf("completed@%h", a), done, 1'b1);

    if (exp_miss) begin
      res_valid[idx] = 1'b1;
      res_line[idx]  = line_a;
      res_dirty[idx] = 1'b0;
    end
    if (we && !drop_in_wb) begin
      arch_mem[a >> 2] = store_word(arch_word(a >> 2), d, sz, a[1:0]);
      res_dirty[idx]   = 1'b1;
    end
    @(negedge clk_i);
    access_i    = 1'b0;
    mem_ready_i = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [31:0] ra;

    for (int i = 0; i < 64; i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
      res_line[i]  = '0;
    end
    reset_i       = 1'b1;
    access_i      = 1'b0;
    addr_i        = '0;
    wr_en_i       = 1'b0;
    size_i        = SIZE_WORD;
    wr_data_i     = '0;
    mem_rd_data_i = '0;
    mem_ready_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_hit", hit_o, 1'b0);
    check("rst_mem_rd", mem_rd_o, 1'b0);
    check("rst_mem_wr", mem_wr_o, 1'b0);
    check("rst_rd_data", rd_data_o, 32'h0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Cold load, clean miss, memory answers after 3 cycles
    do_access(32'h0000_1004, 1'b0, SIZE_WORD, 32'h0, 0, 3, 1'b0);
    // Store hit then read-back
    do_access(32'h0000_1008, 1'b1, SIZE_WORD, 32'hDEAD_BEEF, 0, 0, 1'b0);
    do_access(32'h0000_1008, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b0);
    check("readback_deadbeef", arch_word(32'h1008 >> 2), 32'hDEAD_BEEF);
    // Conflict miss with dirty victim
    do_access(32'h0000_2008, 1'b0, SIZE_WORD, 32'h0, 1, 0, 1'b0);
    // Sub-word stores; the HALF overwrites the earlier BYTE lane
    do_access(32'h0000_2003, 1'b1, SIZE_BYTE, 32'hFFFF_FFAB, 0, 0, 1'b0);
    do_access(32'h0000_2002, 1'b1, SIZE_HALF, 32'hFFFF_1234, 0, 0, 1'b0);
    do_access(32'h0000_2000, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b0);
    check("half_over_byte", arch_word(32'h2000 >> 2) >> 16, 32'h0000_1234);

    // Reset in the middle of a refill
    access_i = 1'b1;
    addr_i   = 32'h0000_5040;
    wr_en_i  = 1'b0;
    size_i   = SIZE_WORD;
    cyc = 0;
    while (!mem_rd_o && cyc < 10) begin
      @(negedge clk_i);
      cyc++;
    end
    check("rst_mid_pre_rd", mem_rd_o, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    check("rst_mid_rd_drop", mem_rd_o, 1'b0);
    check("rst_mid_wr_drop", mem_wr_o, 1'b0);
    check("rst_mid_hit", hit_o, 1'b0);
    for (int i = 0; i < 64; i++) res_valid[i] = 1'b0;
    arch_mem = back_mem;  // dirty data held only in the cache is gone
    @(negedge clk_i);
    reset_i  = 1'b0;
    access_i = 1'b0;
    @(negedge clk_i);
    do_access(32'h0000_5040, 1'b0, SIZE_WORD, 32'h0, 0, 1, 1'b0);
    do_access(32'h0000_2000, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b0);

    // Request withdrawn during writeback: transaction still completes
    do_access(32'h0000_2004, 1'b1, SIZE_WORD, 32'h1357_9BDF, 0, 0, 1'b0);
    do_access(32'h0000_6000, 1'b0, SIZE_WORD, 32'h0, 1, 2, 1'b1);
    repeat (2) begin
      @(negedge clk_i);
      check("drop_quiet", {hit_o, mem_rd_o, mem_wr_o}, 3'b000);
    end
    do_access(32'h0000_6000, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b0);

    // Random traffic over four tags and eight indices to force evictions
    for (int n = 0; n < 300; n++) begin
      ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
         | 32'($urandom_range(0, 15));
      do_access(ra, 1'($urandom_range(0, 1)), mem_access_size_t'($urandom_range(0, 2)),
                $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
